adder_serial: RTL and testbench

- Multi-cycle, digit-serial adder/subtractor: processes WIDTH-bit operands LSB-first, DIGIT bits per clock, with a single carry flip-flop between digits.
- Parametrised successor of the combinational ha/fa cells; the per-digit datapath is a DIGIT-long ripple chain of the team's fa cell.
- Used where area matters more than latency. Sits between a register-file/bus master (start/done handshake) and result consumers.

---
 rtl/adder_serial.sv | 125 ++++++++++++
 tb/tb_adder_serial.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial.sv
// adder_serial: digit-serial adder/subtractor, LSB-first, DIGIT bits per clock.
// Operands are latched on an accepted start and consumed DIGIT bits per edge.
// A single carry flip-flop links consecutive digits.
// Optional feature macro: ADDER_SERIAL_OVF_EN adds the signed overflow output ovf.
module adder_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
`ifdef ADDER_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);

  localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject illegal parameter combinations at elaboration.
  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "adder_serial: WIDTH must be >= 2");
  end
  if (DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $fatal(1, "adder_serial: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] s_shift;
  logic             last;

  // One digit of full-adder cells, carry rippling from the carry flip-flop upward.
  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = cy;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i]  = opa[i] ^ opb[i] ^ c[i];
      c[i+1]   = (opa[i] & opb[i]) | (c[i] & (opa[i] ^ opb[i]));
    end
  end

  // New digit enters s from the MSB side; after N digits s is fully aligned.
  always_comb begin
    s_shift = (s >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    last    = (cnt == CW'(N - 1));
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            cy    <= sub;
            s     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa <= opa >> DIGIT;
          opb <= opb >> DIGIT;
          s   <= s_shift;
          cy  <= c[DIGIT];
          cnt <= CW'(cnt + 1'b1);
          if (last) begin
            co    <= c[DIGIT];
`ifdef ADDER_SERIAL_OVF_EN
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
// Directed bench for adder_serial: table vectors on 8-bit builds, corner
// sequences (start during RUN/DONE, mid-run reset), and a 4-bit sweep.
module tb_adder_serial;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 8-bit instances: DIGIT=1 and DIGIT=4
  logic [7:0] a8, b8;
  logic       sub8, st81, st84;
  logic       bz81, dn81, co81, bz84, dn84, co84;
  logic [7:0] s81, s84;
`ifdef ADDER_SERIAL_OVF_EN
  logic       ov81, ov84;
`endif

  adder_serial #(.WIDTH(8), .DIGIT(1)) u8d1 (
    .clock(clock), .reset_n(reset_n), .start(st81), .sub(sub8), .a(a8), .b(b8),
    .busy(bz81), .done(dn81), .s(s81),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ov81),
`endif
    .co(co81));

  adder_serial #(.WIDTH(8), .DIGIT(4)) u8d4 (
    .clock(clock), .reset_n(reset_n), .start(st84), .sub(sub8), .a(a8), .b(b8),
    .busy(bz84), .done(dn84), .s(s84),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ov84),
`endif
    .co(co84));

  // 4-bit instances: DIGIT = 1, 2, 4 driven in parallel
  logic [3:0] a4, b4;
  logic       sub4, st4;
  logic [3:0] s4 [3];
  logic       co4 [3];
  logic       dn4 [3];
  logic       bz4 [3];
`ifdef ADDER_SERIAL_OVF_EN
  logic       ov4 [3];
`endif

  adder_serial #(.WIDTH(4), .DIGIT(1)) u4d1 (
    .clock(clock), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
    .busy(bz4[0]), .done(dn4[0]), .s(s4[0]),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ov4[0]),
`endif
    .co(co4[0]));

  adder_serial #(.WIDTH(4), .DIGIT(2)) u4d2 (
    .clock(clock), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
    .busy(bz4[1]), .done(dn4[1]), .s(s4[1]),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ov4[1]),
`endif
    .co(co4[1]));

  adder_serial #(.WIDTH(4), .DIGIT(4)) u4d4 (
    .clock(clock), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
    .busy(bz4[2]), .done(dn4[2]), .s(s4[2]),
`ifdef ADDER_SERIAL_OVF_EN
    .ovf(ov4[2]),
`endif
    .co(co4[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t tbl [7];

  // Wait (bounded) for done on an 8-bit instance; k0 = index of the current negedge after start.
  task automatic wait_done(input int sel, input int k0, output int lat, output int bcnt,
                           output logic [7:0] rs, output logic rco, output logic rov);
    lat = -1; bcnt = 0; rs = '0; rco = 1'b0; rov = 1'b0;
    for (int k = k0; k <= 40; k++) begin
      if ((sel == 0) ? dn81 : dn84) begin
        lat = k - 1;
        rs  = (sel == 0) ? s81 : s84;
        rco = (sel == 0) ? co81 : co84;
`ifdef ADDER_SERIAL_OVF_EN
        rov = (sel == 0) ? ov81 : ov84;
`endif
        break;
      end
      if ((sel == 0) ? bz81 : bz84) bcnt++;
      @(negedge clock);
    end
  endtask

  // Launch one 8-bit operation and collect its result; operands are scrambled after the start edge.
  task automatic run8(input int sel, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                      output logic [7:0] rs, output logic rco, output logic rov,
                      output int lat, output int bcnt);
    @(negedge clock);
    a8 = ia; b8 = ib; sub8 = isub;
    if (sel == 0) st81 = 1'b1; else st84 = 1'b1;
    @(negedge clock);
    st81 = 1'b0; st84 = 1'b0;
    a8 = ~ia; b8 = 8'h5A; sub8 = ~isub;
    wait_done(sel, 1, lat, bcnt, rs, rco, rov);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rco, rov;
    int         lat, bcnt, pulses;

    tbl[0] = '{a: 8'h3C, b: 8'h55, sub: 1'b0, s: 8'h91, co: 1'b0, ovf: 1'b1};
    tbl[1] = '{a: 8'h10, b: 8'h20, sub: 1'b1, s: 8'hF0, co: 1'b0, ovf: 1'b0};
    tbl[2] = '{a: 8'h20, b: 8'h10, sub: 1'b1, s: 8'h10, co: 1'b1, ovf: 1'b0};
    tbl[3] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, co: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, co: 1'b0, ovf: 1'b1};
    tbl[5] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: 8'h7F, co: 1'b1, ovf: 1'b1};
    tbl[6] = '{a: 8'h00, b: 8'h00, sub: 1'b1, s: 8'h00, co: 1'b1, ovf: 1'b0};

    reset_n = 1'b0;
    a8 = '0; b8 = '0; sub8 = 1'b0; st81 = 1'b0; st84 = 1'b0;
    a4 = '0; b4 = '0; sub4 = 1'b0; st4 = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset busy", 32'(bz81), 32'd0);
    chk("reset done", 32'(dn81), 32'd0);
    chk("reset s", 32'(s81), 32'd0);
    chk("reset co", 32'(co81), 32'd0);
    reset_n = 1'b1;

    // Table vectors on both 8-bit digit widths
    for (int i = 0; i < 7; i++) begin
      for (int sel = 0; sel < 2; sel++) begin
        run8(sel, tbl[i].a, tbl[i].b, tbl[i].sub, rs, rco, rov, lat, bcnt);
        chk($sformatf("vec%0d d%0d s", i, sel), 32'(rs), 32'(tbl[i].s));
        chk($sformatf("vec%0d d%0d co", i, sel), 32'(rco), 32'(tbl[i].co));
        chk($sformatf("vec%0d d%0d latency", i, sel), 32'(lat), (sel == 0) ? 32'd8 : 32'd2);
        chk($sformatf("vec%0d d%0d busy cycles", i, sel), 32'(bcnt), (sel == 0) ? 32'd8 : 32'd2);
`ifdef ADDER_SERIAL_OVF_EN
        chk($sformatf("vec%0d d%0d ovf", i, sel), 32'(rov), 32'(tbl[i].ovf));
`endif
      end
    end

    // Result held in IDLE
    repeat (3) @(negedge clock);
    chk("hold s", 32'(s84), 32'h00);
    chk("hold co", 32'(co84), 32'd1);

    // start during RUN is ignored, then start held during DONE runs back-to-back
    @(negedge clock);
    a8 = 8'h3C; b8 = 8'h55; sub8 = 1'b0; st81 = 1'b1;
    @(negedge clock);
    st81 = 1'b0;
    repeat (2) @(negedge clock);
    a8 = 8'h01; b8 = 8'h01; st81 = 1'b1;
    @(negedge clock);
    st81 = 1'b0;
    wait_done(0, 4, lat, bcnt, rs, rco, rov);
    chk("midrun s", 32'(rs), 32'h91);
    chk("midrun co", 32'(rco), 32'd0);
    chk("midrun latency", 32'(lat), 32'd8);
    a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; st81 = 1'b1;
    @(negedge clock);
    st81 = 1'b0;
    chk("b2b busy", 32'(bz81), 32'd1);
    wait_done(0, 1, lat, bcnt, rs, rco, rov);
    chk("b2b s", 32'(rs), 32'h02);
    chk("b2b co", 32'(rco), 32'd0);
    chk("b2b latency", 32'(lat), 32'd8);

    // Reset asserted at RUN cycle 3 aborts immediately without done
    @(negedge clock);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; st81 = 1'b1;
    @(negedge clock);
    st81 = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(bz81), 32'd0);
    chk("abort done", 32'(dn81), 32'd0);
    chk("abort s", 32'(s81), 32'd0);
    chk("abort co", 32'(co81), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (dn81 || bz81) pulses++;
      @(negedge clock);
    end
    chk("abort no done", 32'(pulses), 32'd0);
    run8(0, 8'h20, 8'h10, 1'b1, rs, rco, rov, lat, bcnt);
    chk("post-reset s", 32'(rs), 32'h10);
    chk("post-reset co", 32'(rco), 32'd1);
    chk("post-reset latency", 32'(lat), 32'd8);

    // Exhaustive 4-bit sweep across DIGIT = 1, 2, 4
    for (int sb = 0; sb < 2; sb++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          logic [4:0] got_v [3];
          logic       got_o [3];
          int         lt [3];
          logic       seen [3];
          logic [3:0] bb;
          logic [4:0] e;
          int         ra, rb, r;
          logic       eov;
          @(negedge clock);
          a4 = 4'(ai); b4 = 4'(bi); sub4 = sb[0]; st4 = 1'b1;
          @(negedge clock);
          st4 = 1'b0; a4 = ~a4; b4 = 4'h9;
          for (int j = 0; j < 3; j++) begin
            seen[j] = 1'b0; lt[j] = -1; got_v[j] = '0; got_o[j] = 1'b0;
          end
          for (int k = 1; k <= 12; k++) begin
            for (int j = 0; j < 3; j++) begin
              if (dn4[j] && !seen[j]) begin
                seen[j]  = 1'b1;
                lt[j]    = k - 1;
                got_v[j] = {co4[j], s4[j]};
`ifdef ADDER_SERIAL_OVF_EN
                got_o[j] = ov4[j];
`endif
              end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge clock);
          end
          bb  = (sb != 0) ? ~(4'(bi)) : 4'(bi);
          e   = 5'(ai) + 5'(bb) + 5'(sb);
          ra  = (ai >= 8) ? ai - 16 : ai;
          rb  = (bi >= 8) ? bi - 16 : bi;
          r   = (sb != 0) ? ra - rb : ra + rb;
          eov = (r > 7) || (r < -8);
          for (int j = 0; j < 3; j++) begin
            chk($sformatf("w4 d%0d %s a=%0h b=%0h {co,s}", 1 << j, sb ? "sub" : "add", ai, bi),
                32'(got_v[j]), 32'(e));
            chk($sformatf("w4 d%0d latency", 1 << j), 32'(lt[j]), 32'(4 >> j));
`ifdef ADDER_SERIAL_OVF_EN
            chk($sformatf("w4 d%0d %s a=%0h b=%0h ovf", 1 << j, sb ? "sub" : "add", ai, bi),
                32'(got_o[j]), 32'(eov));
`endif
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
